// File: rtl/nand_selftest_pkg.sv
// Shared types, bit indices and golden truth table
// for the NAND basic-gate self-test.
package nand_selftest_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK,
        S_DONE
    } state_e;

    localparam int Y_NOT  = 0;
    localparam int Y_AND  = 1;
    localparam int Y_OR   = 2;
    localparam int Y_NAND = 3;
    localparam int Y_NOR  = 4;
    localparam int Y_XOR  = 5;
    localparam int Y_XNOR = 6;

    localparam logic [6:0] GOLDEN [4] = '{
        7'h59,
        7'h2D,
        7'h2C,
        7'h46
    };

    function automatic logic [6:0] golden_of(input logic [1:0] vec);
        return GOLDEN[vec];
    endfunction

endpackage

// File: rtl/nand_gates_selftest_if.sv
// Bus between the self-test wrapper and the gate block:
// A/B stimulus one way, the seven gate outputs the other.
interface nand_gates_selftest_if;
    logic       a;
    logic       b;
    logic [6:0] y;

    modport master (
        output a,
        output b,
        input  y
    );

    modport slave (
        input  a,
        input  b,
        output y
    );
endinterface

// File: rtl/nand_gates_selftest.sv
// Sweeps A/B through all four vectors, checks the gate
// block outputs against the golden table and keeps results.
module nand_gates_selftest
    import nand_selftest_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             drv_a,
    output logic             drv_b,
    input  logic [6:0]       y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_fail_vec,
    output logic [6:0]       first_fail_mask
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;
    logic [1:0]       ffv_q, ffv_d;
    logic [6:0]       ffm_q, ffm_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       drv_q, drv_d;
    logic [6:0]       diff;

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        pcnt_d   = pcnt_q;
        err_d    = err_q;
        pass_d   = pass_q;
        ffv_d    = ffv_q;
        ffm_d    = ffm_q;
        diff     = y_in ^ golden_of(vec_q);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d    = '0;
                    pass_d   = 1'b0;
                    ffv_d    = '0;
                    ffm_d    = '0;
                    pcnt_d   = '0;
                    vec_d    = '0;
                    settle_d = SETTLE_LOAD;
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (settle_q == '0) state_d = S_CHECK;
                else settle_d = settle_q - 1'b1;
            end
            S_CHECK: begin
                // err_q still zero means this is the run's first miss
                if (diff != '0) begin
                    if (err_q != '1) err_d = err_q + 1'b1;
                    if (err_q == '0) begin
                        ffv_d = vec_q;
                        ffm_d = diff;
                    end
                end
                settle_d = SETTLE_LOAD;
                if (vec_q != 2'b11) begin
                    vec_d   = vec_q + 1'b1;
                    state_d = S_DRIVE;
                end else if (int'(pcnt_q) < PASSES - 1) begin
                    pcnt_d  = pcnt_q + 1'b1;
                    vec_d   = '0;
                    state_d = S_DRIVE;
                end else begin
                    pass_d  = (err_d == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_DRIVE) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        drv_d  = busy_d ? vec_d : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            pcnt_q   <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
            ffv_q    <= '0;
            ffm_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            drv_q    <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            pcnt_q   <= pcnt_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
            ffv_q    <= ffv_d;
            ffm_q    <= ffm_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            drv_q    <= drv_d;
        end
    end

    assign drv_a           = drv_q[1];
    assign drv_b           = drv_q[0];
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_fail_vec  = ffv_q;
    assign first_fail_mask = ffm_q;

endmodule

// File: tb/tb_nand_gates_selftest.sv
// Three wrapper configurations, each around a behavioural
// gate block with an injectable fault mode.
module tb_nand_gates_selftest;
    import nand_selftest_pkg::*;

    typedef struct {
        int         inst;
        int         fault;
        int         err;
        logic       pass;
        logic [1:0] ffv;
        logic [6:0] ffm;
        int         done_cyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start [3];
    int   fm [3];
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t sb [$];

    always #5 clk = ~clk;

    nand_gates_selftest_if g0();
    nand_gates_selftest_if g1();
    nand_gates_selftest_if g2();

    logic       busy_w [3];
    logic       done_w [3];
    logic       pass_w [3];
    logic [7:0] err_w [3];
    logic [1:0] ffv_w [3];
    logic [6:0] ffm_w [3];
    logic [1:0] drv_w [3];
    logic [1:0] err2;

    function automatic logic [6:0] gate(input logic a, input logic b, input int f);
        logic [6:0] y;
        y[Y_NOT]  = ~a;
        y[Y_AND]  = a & b;
        y[Y_OR]   = a | b;
        y[Y_NAND] = ~(a & b);
        y[Y_NOR]  = ~(a | b);
        y[Y_XOR]  = a ^ b;
        y[Y_XNOR] = ~(a ^ b);
        if (f == 1) y[Y_XOR] = 1'b0;
        if (f == 2) y[Y_NAND] = 1'b1;
        if (f == 3) y = ~y;
        return y;
    endfunction

    assign g0.y = gate(g0.a, g0.b, fm[0]);
    assign g1.y = gate(g1.a, g1.b, fm[1]);
    assign g2.y = gate(g2.a, g2.b, fm[2]);
    assign drv_w[0] = {g0.a, g0.b};
    assign drv_w[1] = {g1.a, g1.b};
    assign drv_w[2] = {g2.a, g2.b};
    assign err_w[2] = {6'b0, err2};

    nand_gates_selftest dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .drv_a(g0.a), .drv_b(g0.b), .y_in(g0.y),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .first_fail_vec(ffv_w[0]),
        .first_fail_mask(ffm_w[0])
    );

    nand_gates_selftest #(.PASSES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .drv_a(g1.a), .drv_b(g1.b), .y_in(g1.y),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .first_fail_vec(ffv_w[1]),
        .first_fail_mask(ffm_w[1])
    );

    nand_gates_selftest #(.PASSES(2), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]),
        .drv_a(g2.a), .drv_b(g2.b), .y_in(g2.y),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(err2), .first_fail_vec(ffv_w[2]),
        .first_fail_mask(ffm_w[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input int i, input string tag);
        chk({tag, " busy"}, int'(busy_w[i]), 0);
        chk({tag, " done"}, int'(done_w[i]), 0);
        chk({tag, " pass"}, int'(pass_w[i]), 0);
        chk({tag, " err"}, int'(err_w[i]), 0);
        chk({tag, " ffv"}, int'(ffv_w[i]), 0);
        chk({tag, " ffm"}, int'(ffm_w[i]), 0);
        chk({tag, " drv"}, int'(drv_w[i]), 0);
    endtask

    // restart_at/rst_at: cycle number for a stray start or a reset, 0 = none
    task automatic run(input vec_t v, input int restart_at, input int rst_at);
        int   i;
        int   cyc;
        bit   got;
        vec_t e;
        i = v.inst;
        fm[i] = v.fault;
        sb.push_back(v);
        @(negedge clk);
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
        cyc = 1;
        got = 0;
        while (cyc <= 100 && !got) begin
            start[i] = (cyc == restart_at);
            if (i == 0 && v.fault == 0 && rst_at == 0 && cyc <= 12) begin
                chk($sformatf("drv c%0d", cyc), int'(drv_w[0]), (cyc - 1) / 3);
                chk($sformatf("busy c%0d", cyc), int'(busy_w[0]), 1);
            end
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk_zero(i, "midreset");
                void'(sb.pop_back());
                #1;
                rst_n = 1'b1;
                start[i] = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk);
                    #1;
                    if (done_w[i]) got = 1;
                end
                chk("no done after reset", int'(got), 0);
                return;
            end
            if (done_w[i]) begin
                got = 1;
                e = sb.pop_front();
                chk("done cycle", cyc, e.done_cyc);
                chk("pass", int'(pass_w[i]), int'(e.pass));
                chk("err_count", int'(err_w[i]), e.err);
                chk("first_fail_vec", int'(ffv_w[i]), int'(e.ffv));
                chk("first_fail_mask", int'(ffm_w[i]), int'(e.ffm));
                chk("drv in done", int'(drv_w[i]), 0);
                chk("busy in done", int'(busy_w[i]), 0);
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start[i] = 1'b0;
        if (!got) begin
            chk("done timeout", 0, 1);
            void'(sb.pop_front());
        end else begin
            @(posedge clk);
            #1;
            chk("done one cycle", int'(done_w[i]), 0);
            chk("pass held", int'(pass_w[i]), int'(v.pass));
        end
    endtask

    vec_t tbl [5];

    initial begin
        tbl[0] = '{0, 0, 0, 1'b1, 2'b00, 7'h00, 13};
        tbl[1] = '{0, 1, 2, 1'b0, 2'b01, 7'h20, 13};
        tbl[2] = '{1, 2, 3, 1'b0, 2'b11, 7'h08, 37};
        tbl[3] = '{2, 3, 3, 1'b0, 2'b00, 7'h7F, 25};
        tbl[4] = '{0, 0, 0, 1'b1, 2'b00, 7'h00, 13};
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            fm[i] = 0;
        end
        #12;
        for (int i = 0; i < 3; i++) chk_zero(i, "reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int t = 0; t < 5; t++) run(tbl[t], 0, 0);

        run(tbl[1], 5, 0);
        run(tbl[0], 0, 6);
        run(tbl[0], 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/nand_gates_selftest.md
Name: nand_gates_selftest

Overview:
- Sequential stimulus generator and checker that sits directly upstream and downstream of the NAND-built basic-gate block.
- Drives the gate block's A/B inputs exhaustively through 00, 01, 10, 11 and samples its seven outputs after a settle time.
- Compares those outputs against a golden truth table and reports pass/fail, a saturating mismatch count and the first failing vector.
- Used as the on-board self-test wrapper for the gate experiment.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling (legal range >= 1)
PASSES, 1, number of complete 4-vector sweeps per run (legal range >= 1)
ERR_W, 8, width of the mismatch counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse to begin a run; sampled only in IDLE
drv_a  output  1  drives A of the gate block
drv_b  output  1  drives B of the gate block
y_in  input  7  gate outputs; bit 0 not, 1 and, 2 or, 3 nand, 4 nor, 5 xor, 6 xnor
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse when a run completes
pass  output  1  1 when the last completed run had zero mismatches
err_count  output  ERR_W  mismatching vectors in the last run, saturating at all-ones
first_fail_vec  output  2  {A,B} of the first mismatching vector
first_fail_mask  output  7  XOR of y_in and golden at the first mismatch

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: while rst_n is low, all outputs are 0, the FSM is in IDLE and all counters are cleared. Reset mid-run aborts immediately with no done pulse.
- Golden table {A,B} -> y bits [6:0]:
  - 00 -> 7'h59
  - 01 -> 7'h2D
  - 10 -> 7'h2C
  - 11 -> 7'h46
- IDLE:
  - busy=0.
  - Results from the previous run are held.
  - start=1 clears err_count, pass, first_fail_vec, first_fail_mask and the pass counter.
  - It also loads vector 00, loads the settle counter with SETTLE_CYCLES-1, and goes to DRIVE.
- DRIVE:
  - busy=1 and {drv_a,drv_b}=current vector.
  - The settle counter decrements each cycle; at 0 the FSM goes to CHECK.
- CHECK (one cycle):
  - busy=1 and the vector is still driven.
  - y_in is compared with the golden value for the vector.
  - On mismatch, err_count increments, saturating at 2^ERR_W-1. If this is the first mismatch of the run, first_fail_vec and first_fail_mask are captured.
  - If the vector is not 11: advance the vector and go to DRIVE.
  - If the vector is 11 and the pass counter < PASSES-1: increment the pass counter, wrap the vector to 00 and go to DRIVE.
  - Otherwise go to DONE.
- DONE (one cycle):
  - busy=0, done=1, pass=(err_count==0), including any mismatch counted in the final CHECK.
  - drv_a and drv_b return to 0. Next state is IDLE.
- Timing: with start sampled at edge 0, busy is high for cycles 1..PASSES*4*(SETTLE_CYCLES+1), and done is high in the cycle after that. For the defaults this is busy cycles 1..12 and done in cycle 13.
- start while busy or in DONE is ignored; there is no queuing.
- The mismatch count is per vector, not per bit. first_fail values are held until the next accepted start.
- y_in is sampled only in CHECK; its value in other states has no effect.

Decomposition:
- Package nand_selftest_pkg holds:
  - the state enum (IDLE, DRIVE, CHECK, DONE)
  - localparam bit indices for the seven outputs
  - the 4-entry GOLDEN array of 7-bit words
  - a pure function golden_of(vec) returning the expected word
- No sub-module is needed; the FSM, settle/vector/pass counters and compare logic live in one module.
- The bench instantiates this block together with the gate block.

Test Plan:
- Correct gate block, defaults, start at cycle 0 -> drive sequence 00,01,10,11 with 3 cycles each; done in cycle 13; pass=1, err_count=0, first_fail_mask=0.
- y_xor forced stuck-at-0 -> mismatches at 01 and 10; err_count=2, pass=0, first_fail_vec=2'b01, first_fail_mask=7'h20.
- PASSES=3 with y_nand stuck-at-1 -> mismatch only at 11 in each sweep; err_count=3; first_fail_vec=2'b11, first_fail_mask=7'h08; done at cycle 37.
- ERR_W=2, PASSES=2, y_in = ~golden -> 8 mismatching vectors; err_count saturates at 3; first_fail_vec=00, first_fail_mask=7'h7F.
- start pulsed again in cycle 5 of a run -> ignored; done still in cycle 13 with unchanged results.
- rst_n low during cycle 6 of a run -> all outputs 0 asynchronously, no done pulse; a following start gives a clean run with pass=1.
